// File: rtl/playlist_mcu.sv
// playlist_mcu: master control for the song player.
// Sequences playback over NUM_SONGS songs. Handles play/pause, next/prev,
// song-done and repeat modes. It drives song index, play enable and a
// reset_player pulse that lasts RESET_CYCLES cycles on every song change.
// Optional feature macro: SHUFFLE_EN adds a shuffle input and an 8-bit
// Galois LFSR that picks the next song at random.
//
// state   | meaning
// --------+---------------------------------------------------------------
// PAUSED  | idle, play=0, buttons sampled
// PLAYING | play=1, buttons and song_done sampled
// RESTART | reset_player=1, play=0, inputs ignored for RESET_CYCLES cycles
module playlist_mcu #(
  parameter int NUM_SONGS    = 4,
  parameter int SONG_W       = 2,
  parameter int RESET_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_button,
  input  logic              next_button,
  input  logic              prev_button,
  input  logic              song_done,
  input  logic [1:0]        repeat_mode,
`ifdef SHUFFLE_EN
  input  logic              shuffle,
`endif
  output logic              play,
  output logic              reset_player,
  output logic [SONG_W-1:0] song,
  output logic              playlist_done
);

  typedef enum logic [1:0] {PAUSED, PLAYING, RESTART} state_t;

  localparam logic [SONG_W-1:0] LAST     = SONG_W'(NUM_SONGS - 1);
  localparam logic [3:0]        CNT_INIT = 4'(RESET_CYCLES - 1);

  state_t      state;
  logic        resume;
  logic [3:0]  cnt;

  logic        active;
  logic        ev_next;
  logic        ev_prev;
  logic        ev_done;
  logic        start_restart;
  logic [SONG_W-1:0] fwd_song;
  logic        at_end;

  function automatic logic [SONG_W-1:0] inc_wrap(input logic [SONG_W-1:0] s);
    return (s == LAST) ? '0 : s + SONG_W'(1);
  endfunction

  function automatic logic [SONG_W-1:0] dec_wrap(input logic [SONG_W-1:0] s);
    return (s == '0) ? LAST : s - SONG_W'(1);
  endfunction

  // Event decode with priority next > prev > song_done > play_button
  assign active        = (state == PAUSED) || (state == PLAYING);
  assign ev_next       = active && next_button;
  assign ev_prev       = active && !next_button && prev_button;
  assign ev_done       = (state == PLAYING) && !next_button && !prev_button && song_done;
  assign start_restart = ev_next || ev_prev || ev_done;

`ifdef SHUFFLE_EN
  logic [7:0]        lfsr;
  logic [SONG_W-1:0] adv_cnt;
  logic [SONG_W-1:0] cand;
  logic              stop_mode;

  // Candidate from LFSR; bumped by one if it would repeat the current song
  assign cand      = SONG_W'({1'b0, lfsr} % 9'(NUM_SONGS));
  assign fwd_song  = shuffle ? ((cand == song) ? inc_wrap(cand) : cand) : inc_wrap(song);
  assign at_end    = shuffle ? (adv_cnt == LAST) : (song == LAST);
  assign stop_mode = (repeat_mode == 2'b00) || (repeat_mode == 2'b11);

  // Galois LFSR x^8+x^6+x^5+x^4+1, free running
  always_ff @(posedge clk) begin
    if (reset) lfsr <= 8'h01;
    else       lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
  end

  // Advances since playlist start; cleared by presses and playlist end
  always_ff @(posedge clk) begin
    if (reset) begin
      adv_cnt <= '0;
    end else if (ev_next || ev_prev) begin
      adv_cnt <= '0;
    end else if (ev_done && repeat_mode != 2'b10) begin
      if (stop_mode && at_end)  adv_cnt <= '0;
      else if (adv_cnt != LAST) adv_cnt <= adv_cnt + SONG_W'(1);
    end
  end
`else
  assign fwd_song = inc_wrap(song);
  assign at_end   = (song == LAST);
`endif

  // Main control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= PAUSED;
      song          <= '0;
      play          <= 1'b0;
      reset_player  <= 1'b0;
      playlist_done <= 1'b0;
      resume        <= 1'b0;
      cnt           <= '0;
    end else begin
      playlist_done <= 1'b0;
      case (state)
        PAUSED, PLAYING: begin
          if (ev_next) begin
            song   <= fwd_song;
            resume <= (state == PLAYING);
          end else if (ev_prev) begin
            song   <= dec_wrap(song);
            resume <= (state == PLAYING);
          end else if (ev_done) begin
            case (repeat_mode)
              2'b10: resume <= 1'b1;
              2'b01: begin
                song   <= fwd_song;
                resume <= 1'b1;
              end
              default: begin
                if (at_end) begin
                  song          <= '0;
                  resume        <= 1'b0;
                  playlist_done <= 1'b1;
                end else begin
                  song   <= fwd_song;
                  resume <= 1'b1;
                end
              end
            endcase
          end else if (play_button) begin
            state <= (state == PAUSED) ? PLAYING : PAUSED;
            play  <= (state == PAUSED);
          end
          if (start_restart) begin
            state        <= RESTART;
            play         <= 1'b0;
            reset_player <= 1'b1;
            cnt          <= CNT_INIT;
          end
        end
        RESTART: begin
          if (cnt == '0) begin
            state        <= resume ? PLAYING : PAUSED;
            play         <= resume;
            reset_player <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state        <= PAUSED;
          play         <= 1'b0;
          reset_player <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_playlist_mcu.sv
// Directed bench for playlist_mcu: one instance with 4 songs and a 3-cycle
// restart, one with 3 songs and a 1-cycle restart.
module tb_playlist_mcu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_reset, a_play_b, a_next, a_prev, a_done;
  logic [1:0] a_mode;
  logic       a_play, a_rp, a_pd;
  logic [1:0] a_song;

  logic       b_reset, b_play_b, b_next, b_prev, b_done;
  logic [1:0] b_mode;
  logic       b_play, b_rp, b_pd;
  logic [1:0] b_song;

  int passed = 0;
  int total  = 0;

  playlist_mcu #(.NUM_SONGS(4), .SONG_W(2), .RESET_CYCLES(3)) dut_a (
    .clk(clk), .reset(a_reset), .play_button(a_play_b), .next_button(a_next),
    .prev_button(a_prev), .song_done(a_done), .repeat_mode(a_mode),
    .play(a_play), .reset_player(a_rp), .song(a_song), .playlist_done(a_pd)
  );

  playlist_mcu #(.NUM_SONGS(3), .SONG_W(2), .RESET_CYCLES(1)) dut_b (
    .clk(clk), .reset(b_reset), .play_button(b_play_b), .next_button(b_next),
    .prev_button(b_prev), .song_done(b_done), .repeat_mode(b_mode),
    .play(b_play), .reset_player(b_rp), .song(b_song), .playlist_done(b_pd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_press(input logic n, input logic p, input logic d, input logic pl);
    a_next = n; a_prev = p; a_done = d; a_play_b = pl;
    step();
    a_next = 0; a_prev = 0; a_done = 0; a_play_b = 0;
  endtask

  task automatic b_press(input logic n, input logic p, input logic pl);
    b_next = n; b_prev = p; b_play_b = pl;
    step();
    b_next = 0; b_prev = 0; b_play_b = 0;
  endtask

  task automatic a_finish();
    repeat (3) step();
  endtask

  initial begin
    a_reset = 1; a_play_b = 0; a_next = 0; a_prev = 0; a_done = 0; a_mode = 2'b01;
    b_reset = 1; b_play_b = 0; b_next = 0; b_prev = 0; b_done = 0; b_mode = 2'b01;
    @(negedge clk);
    step(); step();
    check("rst_song", a_song, 0);
    check("rst_play", a_play, 0);
    check("rst_rp", a_rp, 0);
    check("rst_pd", a_pd, 0);
    a_reset = 0; b_reset = 0;

    // play from paused
    a_press(0, 0, 0, 1);
    check("t1_play", a_play, 1);
    check("t1_song", a_song, 0);
    check("t1_rp", a_rp, 0);

    // repeat-all song_done, 3-cycle restart
    a_mode = 2'b01;
    a_press(0, 0, 1, 0);
    check("t2_song", a_song, 1);
    check("t2_rp0", a_rp, 1);
    check("t2_play0", a_play, 0);
    step(); check("t2_rp1", a_rp, 1);
    step(); check("t2_rp2", a_rp, 1);
    check("t2_play2", a_play, 0);
    step(); check("t2_rp_end", a_rp, 0);
    check("t2_play_end", a_play, 1);

    // pause, then prev/next while paused
    a_press(0, 0, 0, 1);
    check("pause", a_play, 0);
    a_press(0, 1, 0, 0);
    check("t3_prev1", a_song, 0);
    check("t3_prev1_rp", a_rp, 1);
    a_finish();
    a_press(0, 1, 0, 0);
    check("t3_prev_wrap", a_song, 3);
    a_finish();
    check("t3_paused_play", a_play, 0);
    check("t3_paused_rp", a_rp, 0);
    a_press(1, 0, 0, 0);
    check("t3_next_wrap", a_song, 0);
    a_finish();
    a_press(1, 0, 0, 0);
    check("t3_next", a_song, 1);
    a_finish();
    check("t3_end_play", a_play, 0);

    // next beats prev on the same edge
    a_press(1, 1, 0, 0);
    check("prio_next_prev", a_song, 2);
    a_finish();

    // stop-at-end from last song
    a_press(0, 0, 0, 1);
    a_press(1, 0, 0, 0);
    a_finish();
    check("t4_song3", a_song, 3);
    check("t4_playing", a_play, 1);
    a_mode = 2'b00;
    a_press(0, 0, 1, 0);
    check("t4_song0", a_song, 0);
    check("t4_pd", a_pd, 1);
    step(); check("t4_pd_pulse", a_pd, 0);
    step(); step();
    check("t4_paused", a_play, 0);
    check("t4_rp", a_rp, 0);
    step(); check("t4_stay_paused", a_play, 0);

    // repeat-one at song 2; mode change during restart has no effect
    a_press(0, 0, 0, 1);
    a_press(1, 0, 0, 0); a_finish();
    a_press(1, 0, 0, 0); a_finish();
    a_mode = 2'b10;
    a_press(0, 0, 1, 0);
    check("rep1_song", a_song, 2);
    check("rep1_rp", a_rp, 1);
    a_mode = 2'b01;
    a_finish();
    check("rep1_song_end", a_song, 2);
    check("rep1_play", a_play, 1);

    // next + song_done same edge, play_button during restart
    a_press(0, 1, 0, 0); a_finish();
    check("t5_song1", a_song, 1);
    a_press(1, 0, 1, 0);
    check("t5_song2", a_song, 2);
    a_press(0, 0, 0, 1);
    check("t5_ign_play", a_play, 0);
    check("t5_ign_rp", a_rp, 1);
    step(); step();
    check("t5_exit_play", a_play, 1);
    check("t5_exit_rp", a_rp, 0);
    step();
    check("t5_one_restart", a_rp, 0);
    check("t5_song_keep", a_song, 2);

    // mode 11 behaves as stop-at-end
    a_press(1, 0, 0, 0); a_finish();
    a_mode = 2'b11;
    a_press(0, 0, 1, 0);
    check("m11_song", a_song, 0);
    check("m11_pd", a_pd, 1);
    a_finish();
    check("m11_paused", a_play, 0);

    // reset in the middle of a restart
    a_press(0, 0, 0, 1);
    a_press(1, 0, 0, 0);
    check("t6_song1", a_song, 1);
    step();
    a_reset = 1; a_next = 1;
    step();
    a_reset = 0; a_next = 0;
    check("t6_song", a_song, 0);
    check("t6_play", a_play, 0);
    check("t6_rp", a_rp, 0);
    step();
    check("t6_hold_play", a_play, 0);
    check("t6_hold_rp", a_rp, 0);
    a_press(0, 0, 0, 1);
    check("t6_was_paused", a_play, 1);

    // 3 songs, 1-cycle restart
    b_press(1, 0, 0);
    check("b_next1", b_song, 1);
    check("b_rp", b_rp, 1);
    step(); check("b_rp_end", b_rp, 0);
    b_press(1, 0, 0); step();
    check("b_next2", b_song, 2);
    b_press(1, 0, 0); step();
    check("b_wrap0", b_song, 0);
    b_press(0, 1, 0); step();
    check("b_prev_wrap", b_song, 2);
    b_press(0, 0, 1);
    check("b_play", b_play, 1);
    b_press(1, 0, 0);
    check("b_n_song", b_song, 0);
    check("b_n_rp", b_rp, 1);
    check("b_n_play", b_play, 0);
    step();
    check("b_n1_rp", b_rp, 0);
    check("b_n1_play", b_play, 1);
    check("b_pd", b_pd, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/playlist_mcu.md
Name: playlist_mcu

Overview:
Parametrised successor to the music-player master control unit. Sequences playback over NUM_SONGS songs. Handles play/pause, next/previous and song-done events, and supports repeat modes. Drives the song player's song index, play enable and reset. Sits between the debounced/one-pulsed button front end and the song player.

Parameters:
NUM_SONGS, 4, number of songs; legal range 2..2**SONG_W
SONG_W, 2, width of the song index
RESET_CYCLES, 1, length of the reset_player pulse in cycles on any song change or restart; legal range 1..15

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
play_button  in  1  one-cycle pulse; toggles play/pause
next_button  in  1  one-cycle pulse; advance to the next song
prev_button  in  1  one-cycle pulse; go to the previous song
song_done  in  1  one-cycle pulse from the player; current song finished
repeat_mode  in  2  00 stop-at-end, 01 repeat-all, 10 repeat-one, 11 treated as 00
play  out  1  player enable (registered)
reset_player  out  1  player reset (registered); held RESET_CYCLES cycles
song  out  SONG_W  current song index (registered)
playlist_done  out  1  one-cycle pulse when stop-at-end finishes the last song

Behaviour:
- One clock (clk). reset is synchronous and active-high.
- All outputs are registered. An event sampled at edge N is visible after edge N.
- Reset values: state=PAUSED, song=0, play=0, reset_player=0, playlist_done=0, resume flag=0, counter=0.
- Reset wins over every other input on the same edge, including mid-RESTART.
- States:
  - PAUSED: play=0.
  - PLAYING: play=1.
  - RESTART: play=0, reset_player=1; lasts exactly RESET_CYCLES cycles.
- Event priority, sampled only in PAUSED/PLAYING: next > prev > song_done > play_button. Lower-priority events on the same edge are dropped.
- All inputs are ignored while in RESTART.
- play_button: PAUSED->PLAYING, or PLAYING->PAUSED. No reset_player.
- next_button: song <= (song==NUM_SONGS-1) ? 0 : song+1.
  - resume flag <= (state==PLAYING).
  - Enter RESTART.
- prev_button: song <= (song==0) ? NUM_SONGS-1 : song-1.
  - resume flag and RESTART as for next_button.
- song_done while PAUSED: ignored.
- song_done while PLAYING, by repeat_mode:
  - 10 (repeat-one): song unchanged; resume=1; enter RESTART.
  - 01 (repeat-all): song advances with wrap; resume=1; enter RESTART.
  - 00/11 (stop-at-end), song<NUM_SONGS-1: advance; resume=1; enter RESTART.
  - 00/11, song==NUM_SONGS-1: song <= 0; resume=0; playlist_done=1 for one cycle (same edge); enter RESTART.
- RESTART exit: down-counter loaded with RESET_CYCLES-1 on entry. When the counter is 0, the next edge goes to PLAYING if resume=1, else PAUSED.
- repeat_mode is sampled only at the song_done edge. A change at any other time has no effect.
- Timing, next at edge N with RESET_CYCLES=1:
  - After edge N: song updated, reset_player=1, play=0.
  - After edge N+1: reset_player=0, play restored.
- Width rule: index arithmetic is SONG_W bits. Wrap uses an explicit compare against NUM_SONGS-1, never natural overflow, so non-power-of-2 NUM_SONGS is handled.

Optional Feature:
SHUFFLE_EN
- Defined:
  - Adds input port shuffle (1 bit) and an 8-bit Galois LFSR, polynomial x^8+x^6+x^5+x^4+1.
  - LFSR reset seed is 8'h01; it steps every cycle.
  - While shuffle=1, next_button and the song_done advance (modes 01/00) choose candidate = lfsr % NUM_SONGS.
  - If candidate == song, use candidate+1 with wrap. This guarantees a change.
  - Stop-at-end under shuffle counts advances: playlist_done fires after NUM_SONGS-1 advances since the last playlist start. The advance counter is cleared by reset, by any prev/next press, and by playlist_done.
  - prev_button and repeat-one are unaffected by shuffle.
- Undefined: no shuffle port, no LFSR; sequential behaviour only.

Test Plan:
1. Reset 2 cycles, then play_button pulse -> after that edge play=1, song=0, reset_player=0.
2. Playing, song=0, repeat_mode=01, NUM_SONGS=4, RESET_CYCLES=3; song_done -> song=1, reset_player=1 and play=0 for exactly 3 cycles, then play=1.
3. Paused, song=0: prev_button -> song=3, reset_player 1 cycle, play stays 0 afterwards. Then next_button twice -> song=0, then 1.
4. Playing, song=3, repeat_mode=00: song_done -> song=0, playlist_done=1 for one cycle, ends PAUSED with play=0. Repeat with repeat_mode=10 at song=2 -> song stays 2, play resumes.
5. next_button and song_done on the same edge while playing at song=1 -> song=2, one RESTART only. play_button during RESTART -> ignored, play=1 after exit.
6. reset asserted during a RESTART of length 3 -> next cycle song=0, play=0, reset_player=0, state PAUSED. Separately, NUM_SONGS=3, SONG_W=2: next from song 2 -> song=0, never 3.
